// File: rtl/aes_key_schedule.sv
// AES-128 iterative key schedule: latches a cipher key on start and emits
// round keys 0..10 over a valid/ready handshake, one expansion step per transfer.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin expansion of key_in (sampled only while idle)
//   key_in     128-bit cipher key, w0 = [127:96]
//   rk_ready   downstream accepts round_key this cycle
//   round_key  registered current round key
//   round_idx  index of round_key, 0..10
//   rk_valid   round_key/round_idx valid
//   busy       expansion in progress
//   done       one-cycle pulse after round key 10 is transferred

module subBytes (
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  // Byte x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar g = 0; g < 16; g++) begin : g_byte
    logic [7:0] b;
    assign b = state_i[8*g +: 8];
    // ~b*8+7 == 2047-8*b
    assign state_o[8*g +: 8] = SBOX[{~b, 3'b111} -: 8];
  end

endmodule

module aes_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, rot, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] sb_out;
  logic [95:0]  sb_unused;
  logic [7:0]   rcon_nx;

  assign {w0, w1, w2, w3} = key_q;
  assign rot = {w3[23:0], w3[31:24]};

  subBytes u_sb (
    .state_i ({rot, 96'h0}),
    .state_o (sb_out)
  );

  // Only the top word carries the rotated w3; the rest is padding.
  assign sb_unused = sb_out[95:0];

  assign t  = sb_out[127:96] ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rcon_nx = {rcon_q[6:0], 1'b0}
                 ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          key_d   = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (idx_q == 4'd10) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d  = {n0, n1, n2, n3};
            idx_d  = idx_q + 4'd1;
            rcon_d = rcon_nx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;
  assign rk_valid  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: directed FIPS-197 runs plus random keys and
// random back-pressure, checked against a GF(2^8)-based key expansion model.

module tb_aes_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int n_pass = 0;
  int n_total = 0;

  logic [127:0] exp_rk [11];
  logic [127:0] cap [11];

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic void expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]),
               sbox_ref(tmp[7:0]), sbox_ref(tmp[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic launch(input logic [127:0] k);
    start = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // mode: 0 ready high, 1 stall pattern, 2 random ready,
  //       3 start re-pulse at idx5, 4 reset at idx6
  task automatic run(input logic [127:0] k, input int mode,
                     input bit chain, input logic [127:0] knext);
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    bit rdy;
    expand(k);
    while (idx < 11 && cyc < 400) begin
      check($sformatf("valid_%0d", idx), rk_valid, 1);
      check($sformatf("busy_%0d", idx), busy, 1);
      check($sformatf("done_lo_%0d", idx), done, 0);
      check($sformatf("idx_%0d", idx), round_idx, idx);
      check($sformatf("key_%0d", idx), round_key, exp_rk[idx]);
      cap[idx] = round_key;
      if (mode == 4 && idx == 6) begin
        rst = 1'b1;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_key", round_key, 0);
        check("rst_idx", round_idx, 0);
        @(posedge clk); #1;
        check("rst_no_emit", rk_valid, 0);
        return;
      end
      if (mode == 1) begin
        if (idx == 4 && stall < 3) begin
          rdy = 1'b0;
          stall++;
        end else rdy = cyc[0];
      end else if (mode == 2) rdy = 1'($urandom_range(0, 1));
      else rdy = 1'b1;
      rk_ready = rdy;
      start = (mode == 3 && idx == 5);
      key_in = start ? '0 : {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      start = 1'b0;
      if (rdy) idx++;
      cyc++;
    end
    check("run_complete", idx, 11);
    check("done_hi", done, 1);
    check("done_valid_lo", rk_valid, 0);
    check("done_busy_lo", busy, 0);
    check("hold_idx", round_idx, 10);
    check("hold_key", round_key, exp_rk[10]);
    if (mode == 0) check("latency", cyc, 11);
    if (chain) begin
      start = 1'b1;
      key_in = knext;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("idle_valid", rk_valid, 0);
      check("idle_key", round_key, exp_rk[10]);
    end
  endtask

  initial begin
    logic [127:0] rk;
    rst = 1'b1;
    start = 1'b0;
    rk_ready = 1'b0;
    key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", rk_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_key", round_key, 0);
    check("reset_idx", round_idx, 0);
    rst = 1'b0;

    rk_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_ready_valid", rk_valid, 0);
    check("idle_ready_key", round_key, 0);

    launch(FIPS);
    run(FIPS, 0, 0, '0);
    check("fips_0", cap[0], FIPS);
    check("fips_1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_2", cap[2], 128'hf2c295f27a96b9435935807a7359f67f);
    check("fips_10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    launch(FIPS);
    run(FIPS, 1, 0, '0);
    check("stall_10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    launch(FIPS);
    run(FIPS, 3, 0, '0);
    check("repulse_10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    launch('0);
    run('0, 0, 1, FIPS);
    check("zero_1", cap[1], 128'h62636363626363636263636362636363);
    check("zero_10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run(FIPS, 0, 0, '0);

    launch(FIPS);
    run(FIPS, 4, 0, '0);
    launch(FIPS);
    run(FIPS, 0, 0, '0);
    check("post_rst_1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);

    for (int n = 0; n < 6; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      launch(rk);
      run(rk, 2, 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
